// File: rtl/lc4_wb_stage_ss.sv
// LC4 superscalar writeback stage register.
// Latches both M-stage lanes, resolves write clashes, tracks NZP and retirement.
module lc4_wb_stage_ss #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic             i_stall,
  input  logic             i_valid_A,
  input  logic             i_valid_B,
  input  logic [2:0]       i_rd_A,
  input  logic [2:0]       i_rd_B,
  input  logic             i_rd_we_A,
  input  logic             i_rd_we_B,
  input  logic [15:0]      i_wdata_A,
  input  logic [15:0]      i_wdata_B,
  input  logic             i_nzp_we_A,
  input  logic             i_nzp_we_B,
  output logic             o_valid_A,
  output logic             o_valid_B,
  output logic [2:0]       o_rd_A,
  output logic [2:0]       o_rd_B,
  output logic             o_rd_we_A,
  output logic             o_rd_we_B,
  output logic [15:0]      o_wdata_A,
  output logic [15:0]      o_wdata_B,
  output logic [2:0]       o_nzp,
  output logic [CNT_W-1:0] o_retired
);

  logic        wr_a;
  logic        wr_b;
  logic        clash;
  logic        set_a;
  logic        set_b;
  logic        nzp_set;
  logic [15:0] nzp_src;
  logic [2:0]  nzp_val;
  logic        cap;

  assign cap   = gwe & ~i_stall;
  assign wr_a  = i_valid_A & i_rd_we_A;
  assign wr_b  = i_valid_B & i_rd_we_B;
  // Younger lane B owns the register when both target the same rd.
  assign clash = wr_a & wr_b & (i_rd_A == i_rd_B);

  assign set_a   = i_valid_A & i_nzp_we_A;
  assign set_b   = i_valid_B & i_nzp_we_B;
  assign nzp_set = set_a | set_b;

  // Pick the youngest NZP setter and encode its sign.
  always_comb begin
    nzp_src = set_b ? i_wdata_B : i_wdata_A;
    nzp_val = 3'b001;
    unique case (1'b1)
      nzp_src[15]:         nzp_val = 3'b100;
      (nzp_src == 16'h0):  nzp_val = 3'b010;
      default:             nzp_val = 3'b001;
    endcase
  end

  // Lane A register: bubble on stall, masked fields when invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_A <= 1'b0;
      o_rd_A    <= 3'd0;
      o_rd_we_A <= 1'b0;
      o_wdata_A <= 16'h0;
    end else if (gwe) begin
      if (i_stall) begin
        o_valid_A <= 1'b0;
        o_rd_A    <= 3'd0;
        o_rd_we_A <= 1'b0;
        o_wdata_A <= 16'h0;
      end else begin
        o_valid_A <= i_valid_A;
        o_rd_A    <= i_valid_A ? i_rd_A : 3'd0;
        o_rd_we_A <= wr_a & ~clash;
        o_wdata_A <= i_valid_A ? i_wdata_A : 16'h0;
      end
    end
  end

  // Lane B register: same capture rules, never loses a clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_B <= 1'b0;
      o_rd_B    <= 3'd0;
      o_rd_we_B <= 1'b0;
      o_wdata_B <= 16'h0;
    end else if (gwe) begin
      if (i_stall) begin
        o_valid_B <= 1'b0;
        o_rd_B    <= 3'd0;
        o_rd_we_B <= 1'b0;
        o_wdata_B <= 16'h0;
      end else begin
        o_valid_B <= i_valid_B;
        o_rd_B    <= i_valid_B ? i_rd_B : 3'd0;
        o_rd_we_B <= wr_b;
        o_wdata_B <= i_valid_B ? i_wdata_B : 16'h0;
      end
    end
  end

  // Condition codes update only on a capture with a setter present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_nzp <= 3'b000;
    end else if (cap && nzp_set) begin
      o_nzp <= nzp_val;
    end
  end

  // Retired counter adds the number of valid lanes captured, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_retired <= '0;
    end else if (cap) begin
      o_retired <= o_retired
                 + CNT_W'(i_valid_A)
                 + CNT_W'(i_valid_B);
    end
  end

endmodule

// File: tb/tb_lc4_wb_stage_ss.sv
// Testbench for lc4_wb_stage_ss.
// Scoreboard of expected W-stage contents plus a small regfile model.
module tb_lc4_wb_stage_ss;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        i_stall;
  logic        i_valid_A, i_valid_B;
  logic [2:0]  i_rd_A, i_rd_B;
  logic        i_rd_we_A, i_rd_we_B;
  logic [15:0] i_wdata_A, i_wdata_B;
  logic        i_nzp_we_A, i_nzp_we_B;
  logic        o_valid_A, o_valid_B;
  logic [2:0]  o_rd_A, o_rd_B;
  logic        o_rd_we_A, o_rd_we_B;
  logic [15:0] o_wdata_A, o_wdata_B;
  logic [2:0]  o_nzp;
  logic [3:0]  o_retired;

  lc4_wb_stage_ss #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .i_stall(i_stall),
    .i_valid_A(i_valid_A), .i_valid_B(i_valid_B),
    .i_rd_A(i_rd_A), .i_rd_B(i_rd_B),
    .i_rd_we_A(i_rd_we_A), .i_rd_we_B(i_rd_we_B),
    .i_wdata_A(i_wdata_A), .i_wdata_B(i_wdata_B),
    .i_nzp_we_A(i_nzp_we_A), .i_nzp_we_B(i_nzp_we_B),
    .o_valid_A(o_valid_A), .o_valid_B(o_valid_B),
    .o_rd_A(o_rd_A), .o_rd_B(o_rd_B),
    .o_rd_we_A(o_rd_we_A), .o_rd_we_B(o_rd_we_B),
    .o_wdata_A(o_wdata_A), .o_wdata_B(o_wdata_B),
    .o_nzp(o_nzp), .o_retired(o_retired)
  );

  always #5 clk = ~clk;

  // Regfile model fed by the W lanes; B written last.
  logic [15:0] rf [8];
  always @(posedge clk) begin
    if (gwe && !rst) begin
      if (o_rd_we_A) rf[o_rd_A] <= o_wdata_A;
      if (o_rd_we_B) rf[o_rd_B] <= o_wdata_B;
    end
  end

  typedef struct {
    logic        va, vb;
    logic [2:0]  rda, rdb;
    logic        wea, web;
    logic [15:0] wda, wdb;
    logic [2:0]  nzp;
    logic [3:0]  ret;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t zero_st();
    exp_t z;
    z.va = 0; z.vb = 0; z.rda = 0; z.rdb = 0;
    z.wea = 0; z.web = 0; z.wda = 0; z.wdb = 0;
    z.nzp = 0; z.ret = 0;
    return z;
  endfunction

  function automatic logic [2:0] enc(logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic cmp_out(string tag, exp_t e);
    chk({tag, ".va"},  32'(o_valid_A), 32'(e.va));
    chk({tag, ".vb"},  32'(o_valid_B), 32'(e.vb));
    chk({tag, ".rda"}, 32'(o_rd_A),    32'(e.rda));
    chk({tag, ".rdb"}, 32'(o_rd_B),    32'(e.rdb));
    chk({tag, ".wea"}, 32'(o_rd_we_A), 32'(e.wea));
    chk({tag, ".web"}, 32'(o_rd_we_B), 32'(e.web));
    chk({tag, ".wda"}, 32'(o_wdata_A), 32'(e.wda));
    chk({tag, ".wdb"}, 32'(o_wdata_B), 32'(e.wdb));
    chk({tag, ".nzp"}, 32'(o_nzp),     32'(e.nzp));
    chk({tag, ".ret"}, 32'(o_retired), 32'(e.ret));
  endtask

  // Drive one cycle, push the expected W contents, pop after the edge.
  task automatic step(
    string tag, logic g, logic st,
    logic va, logic [2:0] ra, logic wa, logic [15:0] da, logic na,
    logic vb, logic [2:0] rb, logic wb, logic [15:0] db, logic nb
  );
    exp_t n;
    exp_t e;
    gwe = g; i_stall = st;
    i_valid_A = va; i_rd_A = ra; i_rd_we_A = wa;
    i_wdata_A = da; i_nzp_we_A = na;
    i_valid_B = vb; i_rd_B = rb; i_rd_we_B = wb;
    i_wdata_B = db; i_nzp_we_B = nb;
    n = m;
    if (g && st) begin
      n.va = 0; n.rda = 0; n.wea = 0; n.wda = 0;
      n.vb = 0; n.rdb = 0; n.web = 0; n.wdb = 0;
    end else if (g) begin
      n.va  = va;
      n.rda = va ? ra : 3'd0;
      n.wda = va ? da : 16'h0;
      n.wea = va & wa;
      n.vb  = vb;
      n.rdb = vb ? rb : 3'd0;
      n.wdb = vb ? db : 16'h0;
      n.web = vb & wb;
      if (n.wea && n.web && ra == rb) n.wea = 0;
      if (vb && nb)      n.nzp = enc(db);
      else if (va && na) n.nzp = enc(da);
      n.ret = m.ret + 4'(va) + 4'(vb);
    end
    m = n;
    q.push_back(n);
    @(posedge clk);
    #1;
    e = q.pop_front();
    cmp_out(tag, e);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".va"},  32'(o_valid_A), 0);
    chk({tag, ".vb"},  32'(o_valid_B), 0);
    chk({tag, ".wea"}, 32'(o_rd_we_A), 0);
    chk({tag, ".web"}, 32'(o_rd_we_B), 0);
    chk({tag, ".wda"}, 32'(o_wdata_A), 0);
    chk({tag, ".wdb"}, 32'(o_wdata_B), 0);
    chk({tag, ".rd"},  32'({o_rd_A, o_rd_B}), 0);
    chk({tag, ".nzp"}, 32'(o_nzp), 0);
    chk({tag, ".ret"}, 32'(o_retired), 0);
  endtask

  initial begin
    rst = 1; gwe = 1; i_stall = 0;
    i_valid_A = 1; i_rd_A = 3; i_rd_we_A = 1;
    i_wdata_A = 16'hFFFF; i_nzp_we_A = 1;
    i_valid_B = 1; i_rd_B = 4; i_rd_we_B = 1;
    i_wdata_B = 16'h0001; i_nzp_we_B = 1;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    m = zero_st();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;

    step("cap", 1, 0, 1, 3, 1, 16'h1234, 1, 1, 5, 1, 16'h8000, 1);
    chk("cap_nzp", 32'(o_nzp), 32'h4);
    chk("cap_ret", 32'(o_retired), 2);

    step("clash", 1, 0, 1, 2, 1, 16'h0001, 0, 1, 2, 1, 16'h0002, 0);
    chk("clash_wea", 32'(o_rd_we_A), 0);
    step("idle", 1, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
    chk("rf_r2", 32'(rf[2]), 32'h0002);

    step("pre_st", 1, 0, 1, 4, 1, 16'hABCD, 1, 0, 0, 0, 16'h0, 0);
    step("stall", 1, 1, 1, 6, 1, 16'h0005, 1, 1, 1, 1, 16'h0000, 1);
    step("pre_g", 1, 0, 1, 1, 1, 16'h0042, 1, 1, 3, 1, 16'h0007, 0);
    step("hold0", 0, 1, 1, 7, 1, 16'h9999, 1, 1, 6, 1, 16'h1111, 1);
    step("hold1", 0, 0, 0, 2, 1, 16'h0000, 1, 1, 2, 1, 16'h8888, 1);
    step("hold2", 0, 1, 1, 5, 0, 16'h7777, 0, 0, 5, 0, 16'h2222, 0);

    step("nzp_z", 1, 0, 1, 1, 1, 16'h0000, 1, 1, 2, 1, 16'h5555, 0);
    chk("nzp_z_lit", 32'(o_nzp), 32'h2);
    step("nzp_h", 1, 0, 1, 1, 1, 16'h8000, 0, 1, 2, 1, 16'h0001, 0);
    chk("nzp_h_lit", 32'(o_nzp), 32'h2);
    step("nzp_p", 1, 0, 1, 1, 1, 16'h7FFF, 1, 0, 2, 1, 16'h8000, 1);
    chk("nzp_p_lit", 32'(o_nzp), 32'h1);
    step("nzp_b", 1, 0, 1, 1, 1, 16'h0003, 1, 1, 2, 1, 16'hFFFE, 1);
    chk("nzp_b_lit", 32'(o_nzp), 32'h4);

    step("inv_a", 1, 0, 0, 4, 1, 16'h3333, 1, 1, 7, 1, 16'h4444, 0);
    step("inv_ab", 1, 0, 0, 4, 1, 16'h3333, 1, 0, 4, 1, 16'h4444, 1);
    step("idle2", 1, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
    chk("rf_r7", 32'(rf[7]), 32'h4444);
    chk("rf_r4", 32'(rf[4]), 32'hABCD);

    step("pre_rst", 1, 0, 1, 3, 1, 16'h0F0F, 1, 1, 6, 1, 16'h0101, 1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk_zero("rst_mid");
    m = zero_st();
    @(posedge clk);
    #1;
    rst = 0;

    for (int p = 1; p <= 16; p++) begin
      step("wrap", 1, 0, 1, 0, 0, 16'h1, 0, 1, 1, 0, 16'h2, 0);
      if (p == 8 || p == 16) chk("wrap_lit", 32'(o_retired), 0);
    end
    for (int p = 0; p < 7; p++)
      step("fill", 1, 0, 1, 0, 0, 16'h1, 0, 1, 1, 0, 16'h2, 0);
    step("one", 1, 0, 1, 0, 0, 16'h1, 0, 0, 1, 0, 16'h2, 0);
    chk("ones", 32'(o_retired), 32'hF);
    step("ovf", 1, 0, 1, 0, 0, 16'h1, 0, 1, 1, 0, 16'h2, 0);
    chk("ovf_lit", 32'(o_retired), 1);

    for (int i = 0; i < 60; i++) begin
      step("rnd",
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           1'($urandom), 3'($urandom), 1'($urandom),
           16'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom_range(0, 1)), 1'($urandom),
           16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
